// File: rtl/hfosc_clkgen.sv
// HFOSC clock generator: power-up startup delay, then NUM_CH run-time
// programmable clock-enable strobes and 50% duty divided clocks.
module hfosc_clkgen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int STARTUP_CYC = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pu_i,
  input  logic                    en_i,
  input  logic                    sync_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic                    ready_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       clk_o
);

  localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;

  typedef enum logic [1:0] {OFF, STARTUP, RUN} state_t;

  state_t                         state, state_n;
  logic [SW-1:0]                  scnt, scnt_n;
  logic                           rdy_n;
  logic                           ch_clr, ch_load, ch_run;

  logic [NUM_CH-1:0][DIV_W-1:0]   div_w;
  logic [NUM_CH-1:0][DIV_W-1:0]   cnt;
  logic [NUM_CH-1:0][DIV_W-1:0]   dact;

  // Packed layout matches the flat bus: channel k is bits [k*DIV_W +: DIV_W].
  assign div_w = div_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OFF;
      scnt    <= '0;
      ready_o <= 1'b0;
    end else begin
      state   <= state_n;
      scnt    <= scnt_n;
      ready_o <= rdy_n;
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    rdy_n   = 1'b0;
    ch_clr  = 1'b0;
    ch_load = 1'b0;
    ch_run  = 1'b0;
    case (state)
      OFF: begin
        ch_clr = 1'b1;
        if (pu_i) begin
          state_n = STARTUP;
          scnt_n  = SW'(STARTUP_CYC - 1);
        end
      end
      STARTUP: begin
        ch_clr = 1'b1;
        if (!pu_i) begin
          state_n = OFF;
          scnt_n  = '0;
        end else if (scnt == '0) begin
          state_n = RUN;
          ch_clr  = 1'b0;
          ch_load = 1'b1;
          rdy_n   = 1'b1;
        end else begin
          scnt_n = scnt - SW'(1);
        end
      end
      RUN: begin
        if (!pu_i) begin
          state_n = OFF;
          ch_clr  = 1'b1;
        end else begin
          rdy_n = 1'b1;
          // sync wins over enable and over a coincident terminal count
          if (sync_i)    ch_load = 1'b1;
          else if (en_i) ch_run  = 1'b1;
        end
      end
      default: begin
        state_n = OFF;
        ch_clr  = 1'b1;
      end
    endcase
  end

  // Per-channel dividers; the active ratio is only reloaded at a period end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      dact   <= '0;
      tick_o <= '0;
      clk_o  <= '0;
    end else if (ch_clr) begin
      cnt    <= '0;
      dact   <= '0;
      tick_o <= '0;
      clk_o  <= '0;
    end else if (ch_load) begin
      cnt    <= '0;
      dact   <= div_w;
      tick_o <= '0;
      clk_o  <= '0;
    end else if (ch_run) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cnt[k] == dact[k]) begin
          tick_o[k] <= 1'b1;
          cnt[k]    <= '0;
          clk_o[k]  <= ~clk_o[k];
          dact[k]   <= div_w[k];
        end else begin
          tick_o[k] <= 1'b0;
          cnt[k]    <= cnt[k] + DIV_W'(1);
        end
      end
    end else begin
      tick_o <= '0;
    end
  end

endmodule

// File: tb/tb_hfosc_clkgen.sv
// Bench for hfosc_clkgen: per-cycle comparison against a period-based
// behavioural model plus directed scenarios with literal expectations.
module tb_hfosc_clkgen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int SC     = 100;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    pu = 1'b0, en = 1'b0, sync = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div = '0;
  logic                    ready_o;
  logic [NUM_CH-1:0]       tick_o, clk_o;

  int checks = 0;
  int errors = 0;
  bit mon = 1'b0;

  hfosc_clkgen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .STARTUP_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .pu_i(pu), .en_i(en), .sync_i(sync),
    .div_i(div), .ready_o(ready_o), .tick_o(tick_o), .clk_o(clk_o)
  );

  always #5 clk = ~clk;

  // Model: m_st 0=off 1=starting 2=running; each channel tracks enabled
  // cycles elapsed in the current period and that period's length.
  int                m_st, m_left;
  bit                m_ready;
  bit [NUM_CH-1:0]   m_tick, m_clk;
  int                m_el[NUM_CH];
  int                m_per[NUM_CH];

  function automatic int dsel(input int k);
    return int'(div[k*DIV_W +: DIV_W]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_left = 0; m_ready = 0; m_tick = '0; m_clk = '0;
      for (int k = 0; k < NUM_CH; k++) begin m_el[k] = 0; m_per[k] = 1; end
    end else if (!pu) begin
      m_st = 0; m_ready = 0; m_tick = '0; m_clk = '0;
    end else if (m_st == 0) begin
      m_st = 1; m_left = SC;
    end else if (m_st == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_st = 2; m_ready = 1;
        for (int k = 0; k < NUM_CH; k++) begin m_el[k] = 0; m_per[k] = dsel(k) + 1; end
      end
    end else if (sync) begin
      m_tick = '0; m_clk = '0;
      for (int k = 0; k < NUM_CH; k++) begin m_el[k] = 0; m_per[k] = dsel(k) + 1; end
    end else if (en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_el[k] = m_el[k] + 1;
        m_tick[k] = 1'b0;
        if (m_el[k] == m_per[k]) begin
          m_tick[k] = 1'b1;
          m_clk[k]  = ~m_clk[k];
          m_el[k]   = 0;
          m_per[k]  = dsel(k) + 1;
        end
      end
    end else begin
      m_tick = '0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon && rst_n) begin
      checks++;
      if ({ready_o, tick_o, clk_o} !== {m_ready, m_tick, m_clk}) begin
        errors++;
        $display("FAIL model t=%0t act ready=%b tick=%b clk=%b exp ready=%b tick=%b clk=%b",
                 $time, ready_o, tick_o, clk_o, m_ready, m_tick, m_clk);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output int lows);
    int n;
    lows = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (!ready_o) lows++;
    end while (!ready_o && n < 1000);
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!tick_o[ch] && n < 1000);
  endtask

  task automatic wait_rise(input int ch, output int n);
    logic prev;
    n = 0;
    prev = clk_o[ch];
    forever begin
      @(negedge clk); n++;
      if ((!prev && clk_o[ch]) || n >= 1000) break;
      prev = clk_o[ch];
    end
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  initial begin
    int n, lows, tog, ntk, bad;
    int tc[NUM_CH];
    int f[NUM_CH];
    logic prev;
    logic [NUM_CH-1:0] held;

    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_clk", clk_o, 0);
    cyc(2);
    rst_n = 1'b1; mon = 1'b1;

    // Startup and basic D=3 timing
    div = {4{8'd3}}; pu = 1'b1; en = 1'b1;
    wait_ready(lows);  chk("startup_lows", lows, 100);
    wait_tick(0, n);   chk("first_tick", n, 4);
    wait_tick(0, n);   chk("tick_period", n, 4);
    wait_rise(0, n);
    wait_rise(0, n);   chk("clk_period", n, 8);

    // Mixed ratios over 2048 cycles
    div = {8'd255, 8'd4, 8'd1, 8'd0};
    pulse_sync();
    for (int k = 0; k < NUM_CH; k++) tc[k] = 0;
    tog = 0; prev = 1'b0;
    repeat (2048) begin
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) if (tick_o[k]) tc[k]++;
      if (clk_o[0] != prev) tog++;
      prev = clk_o[0];
    end
    chk("ticks_d0", tc[0], 2048);
    chk("ticks_d1", tc[1], 1024);
    chk("ticks_d4", tc[2], 409);
    chk("ticks_d255", tc[3], 8);
    chk("clk0_toggles", tog, 2048);

    // Ratio change 9 -> 2 on channel 1 at cnt=5
    div = {8'd3, 8'd3, 8'd9, 8'd3};
    pulse_sync();
    cyc(5);
    div[15:8] = 8'd2;
    wait_tick(1, n);   chk("chg_rest_of_period", n, 5);
    wait_tick(1, n);   chk("chg_new_period_a", n, 3);
    wait_tick(1, n);   chk("chg_new_period_b", n, 3);

    // Enable gating at cnt=2 for 7 cycles, D=4
    div = {4{8'd4}};
    pulse_sync();
    cyc(2);
    en = 1'b0; held = clk_o; ntk = 0; bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (tick_o != '0) ntk++;
      if (clk_o != held) bad++;
    end
    en = 1'b1;
    chk("gated_ticks", ntk, 0);
    chk("gated_clk_hold", bad, 0);
    wait_tick(0, n);   chk("gated_resume", n, 3);

    // Sync colliding with channel 0 terminal count (D={3,5,2,6})
    div = {8'd6, 8'd2, 8'd5, 8'd3};
    pulse_sync();
    cyc(3);
    pulse_sync();
    chk("sync_no_tick", tick_o, 0);
    chk("sync_clk_clear", clk_o, 0);
    for (int k = 0; k < NUM_CH; k++) f[k] = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) if (tick_o[k] && f[k] == 0) f[k] = i;
    end
    chk("sync_next_ch0", f[0], 4);
    chk("sync_next_ch1", f[1], 6);
    chk("sync_next_ch2", f[2], 3);
    chk("sync_next_ch3", f[3], 7);

    // Power drop mid-startup at count 40, re-raise 5 cycles later
    pu = 1'b0; cyc(2);
    pu = 1'b1; cyc(60);
    pu = 1'b0; cyc(5);
    chk("pd_startup_ready", ready_o, 0);
    div = {4{8'd0}};
    pu = 1'b1;
    wait_ready(lows);  chk("restart_lows", lows, 100);

    // Power drop in RUN
    cyc(3);
    pu = 1'b0;
    @(negedge clk);
    chk("pd_run_ready", ready_o, 0);
    chk("pd_run_tick", tick_o, 0);
    chk("pd_run_clk", clk_o, 0);
    pu = 1'b1;
    wait_ready(lows);  chk("rerun_lows", lows, 100);

    // Async reset pulse mid-RUN
    cyc(4);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("arst_ready", ready_o, 0);
    chk("arst_tick", tick_o, 0);
    chk("arst_clk", clk_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    chk("arst_restart_ready", ready_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hfosc_clkgen.md
Name: hfosc_clkgen

Overview:
- Parametrised, synthesizable successor to the fixed-divide HFOSC clock model.
- Runs on the HFOSC output clock. Generates NUM_CH independent clock-enable strobes and divided clocks.
- Each channel's divide ratio is selectable at run time; a new ratio takes effect only at a period boundary.
- Models oscillator power-up latency with a startup counter and a ready flag. Consumed by the sensor/UART timing blocks downstream.

Parameters:
- NUM_CH, 4, number of independent output channels (1..8).
- DIV_W, 8, width of each channel's divide value.
- STARTUP_CYC, 100, clk cycles from power-up request to ready_o (>=1).

Ports:
- clk  input  1  HFOSC clock. All logic is on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- pu_i  input  1  Power-up request (CLKHFPU equivalent). Level sensitive.
- en_i  input  1  Run enable (CLKHFEN equivalent). Level sensitive.
- sync_i  input  1  One-cycle pulse that realigns all channels.
- div_i  input  NUM_CH*DIV_W  Per-channel divide value D. Channel k uses bits [k*DIV_W +: DIV_W].
- ready_o  output  1  High once startup is complete, while in RUN.
- tick_o  output  NUM_CH  One-cycle strobe per channel, once every D+1 enabled cycles.
- clk_o  output  NUM_CH  Divided clock per channel. Toggles on each tick, so period is 2*(D+1) enabled cycles, 50% duty.

Behaviour:
- Reset (rst_n=0, async):
  - state=OFF, startup counter=0.
  - All channel counters=0, D_active=0.
  - ready_o=0, tick_o=0, clk_o=0.
- FSM states are OFF, STARTUP and RUN. Outputs are registered.
- OFF:
  - ready_o=0, tick_o=0, clk_o=0, counters held at 0.
  - pu_i=1 → STARTUP; startup counter loads STARTUP_CYC-1.
- STARTUP:
  - Counter decrements each cycle, regardless of en_i.
  - When it reaches 0 → RUN. On that transition, every D_active[k] loads div_i[k] and every channel counter is cleared.
  - ready_o rises on the first RUN cycle, i.e. STARTUP_CYC cycles after the first clk edge that sampled pu_i=1.
- RUN:
  - ready_o=1.
  - Per channel, when en_i=1: if cnt==D_active, then tick_o[k]=1 for the next cycle, cnt←0, clk_o[k] toggles, and D_active←div_i[k] (shadow reload). Otherwise cnt←cnt+1 and tick_o[k]=0.
  - D=0: tick every enabled cycle; clk_o period is 2 cycles.
  - D=2^DIV_W-1: maximum period; the counter never overflows.
  - en_i=0: counters frozen, tick_o=0, clk_o holds its current level, ready_o stays 1. Counting resumes from the frozen count when en_i returns high.
- div_i changes mid-period are ignored until the next tick. Outputs are never glitched or shortened.
- sync_i=1 in RUN:
  - All cnt←0, D_active←div_i, clk_o←0, tick_o=0 that cycle.
  - sync_i takes priority over a coincident terminal count (no tick), and it acts even when en_i=0.
  - sync_i is ignored in OFF and STARTUP.
- pu_i=0 in any state → OFF on the next edge, with all outputs cleared. This applies mid-STARTUP (the startup count is discarded) and mid-RUN. A new pu_i=1 restarts the full STARTUP_CYC delay.
- pu_i toggles that are shorter than one cycle are not required to be detected.
- Channels are fully independent except for sync_i, en_i and pu_i.

Test Plan:
- Reset and startup, with STARTUP_CYC=100: assert rst_n, then pu_i=1 and en_i=1, D=3 on all channels → ready_o=0 for exactly 100 cycles then 1. The first tick_o arrives 4 cycles after ready_o rises, ticks repeat every 4 cycles, and clk_o has period 8.
- Mixed ratios, D={0,1,4,255}: run 2048 cycles → tick counts are {2048,1024,409/410,8}. clk_o of channel 0 toggles every cycle. No channel interferes with another.
- Ratio change mid-period: on channel 1, change D from 9 to 2 at cnt=5 → the current period still completes at 10 cycles, then periods of 3 follow. No short or extra tick.
- Enable gating: with D=4, drop en_i for 7 cycles at cnt=2 → no ticks while disabled and clk_o level held. The next tick comes 3 enabled cycles after re-enable.
- Sync collision: assert sync_i in the same cycle a channel reaches its terminal count → no tick, all clk_o=0, all counters restart, and the next tick on every channel arrives at D+1 cycles.
- Power-down mid-operation: drop pu_i at startup count 40, re-raise 5 cycles later → full 100-cycle delay again. Dropping pu_i in RUN clears tick_o, clk_o and ready_o on the next edge. An async rst_n pulse mid-RUN clears all outputs immediately.
